tlb_op_ctrl: RTL
================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: op_valid  in  1  TLB op offered by writeback; op_ready  out  1  controller accepts op; op_type  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 reserved; op_pc  in  32  PC of the op; flush  in  1  writeback exception/eret.
REQ-003 SHALL have ports: cp0_index  in  32; cp0_entryhi  in  32; cp0_entrylo0  in  32; cp0_entrylo1  in  32; these are CP0 register values.
REQ-004 SHALL have ports: s1_req  out  1  search-port request; s1_gnt  in  1  grant from the data-side arbiter; s1_urgent  out  1  starvation flag; s1_vpn2  out  19; s1_asid  out  8; s1_found  in  1; s1_index  in  4.
REQ-005 SHALL have ports: r_index  out  4; r_entry  in  78  packed {vpn2,asid,g,pfn0,c0,d0,v0,pfn1,c1,d1,v1}; we  out  1; w_index  out  4; w_entry  out  78, same packing.
REQ-006 SHALL have ports: tlbp_we  out  1; tlbp_p  out  1; tlbp_index  out  4; tlbr_we  out  1; tlbr_data  out  78; cancel_valid  out  1; cancel_pc  out  32; busy  out  1.

Function
REQ-007 SHALL implement the FSM states IDLE, P_REQ, P_WB, R_RD, R_WB, W_WR, CANCEL.
REQ-008 SHALL assert op_ready only in IDLE; busy SHALL equal the state not being IDLE.
REQ-009 On op_valid&&op_ready with flush=0, SHALL latch op_type, op_pc, cp0_index[3:0], entryhi and both entrylo values into a snapshot, and SHALL not sample CP0 again for that op.
REQ-010 A reserved op_type SHALL be accepted and SHALL return to IDLE next cycle with no side effects.
REQ-011 TLBP: IDLE->P_REQ; s1_req=1 with s1_vpn2=entryhi[31:13] and s1_asid=entryhi[7:0] until a cycle with s1_gnt=1; in that cycle SHALL register found/index and go to P_WB.
REQ-012 P_WB: SHALL pulse tlbp_we for 1 cycle with tlbp_p=~found and tlbp_index=index (0 when not found), then go to IDLE; TLBP SHALL NOT raise cancel.
REQ-013 A 3-bit wait counter SHALL increment each P_REQ cycle without grant, saturate at 7, and clear on grant or on leaving P_REQ; s1_urgent SHALL equal (count==7)&&s1_req.
REQ-014 TLBR: R_RD drives r_index=snapshot index and registers r_entry; R_WB pulses tlbr_we for 1 cycle with tlbr_data=registered entry; the FSM then goes to CANCEL.
REQ-015 TLBWI: W_WR pulses we for 1 cycle with w_index=snapshot index and w_entry built from the snapshot: vpn2=entryhi[31:13], asid=entryhi[7:0], g=lo0[0]&lo1[0], pfnN=loN[25:6], cN=loN[5:3], dN=loN[2], vN=loN[1]; the FSM then goes to CANCEL.
REQ-016 CANCEL: SHALL pulse cancel_valid for 1 cycle with cancel_pc=op_pc+32'd4 (wrap modulo 2^32), then go to IDLE.
REQ-017 flush in P_REQ SHALL abort to IDLE with no pulse; flush in any other non-IDLE state SHALL be ignored so the op completes; flush in IDLE SHALL block acceptance that cycle.
REQ-018 Grant and flush in the same P_REQ cycle: flush SHALL win and the search result SHALL be discarded.
REQ-019 All pulse outputs SHALL be registered; at most one of tlbp_we/tlbr_we/we/cancel_valid SHALL be high in any cycle.

Reset
REQ-020 resetn=0 SHALL asynchronously force IDLE, counter=0, and all of tlbp_we, tlbr_we, we, cancel_valid, s1_req, s1_urgent to 0; snapshot and data outputs SHALL reset to 0.
REQ-021 Reset mid-operation SHALL abandon the op with no further pulses after reset deasserts.

Structure
REQ-022 A shared package SHALL hold the op_type encodings, the FSM state enum, the 78-bit entry width constant and the entry field offsets.
REQ-023 One sub-module, tlb_entry_pack, SHALL build w_entry from entryhi/entrylo0/entrylo1.

Verification
REQ-024 TLBP hit: entryhi=0x0000_2005, s1_gnt=1 on first cycle, s1_found=1, s1_index=9 -> tlbp_we pulse 2 cycles after accept, tlbp_p=0, tlbp_index=9, no cancel.
REQ-025 TLBP starvation: s1_gnt=0 for 10 cycles -> s1_urgent rises on the 8th request cycle; grant then leads to tlbp_p=1 (miss), and the counter clears.
REQ-026 TLBWI: index=3, lo0=0x0000_0047, lo1=0x0000_0087 -> we pulse with w_index=3, pfn0=1, pfn1=2, g=1; cancel_pc=op_pc+4 on the following cycle.
REQ-027 TLBR at op_pc=0xFFFF_FFFC -> tlbr_data equals r_entry, cancel_pc=0x0000_0000.
REQ-028 flush during P_REQ with a simultaneous grant -> IDLE, no tlbp_we; flush during W_WR -> we and cancel still occur.
REQ-029 resetn low in R_WB -> all pulse outputs 0 immediately and op_ready=1 after release.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared definitions for the TLB operation controller: op encodings, FSM
// states, entry width and the bit positions of each packed entry field.
package tlb_op_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_RSVD  = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_REQ  = 3'd1,
    P_WB   = 3'd2,
    R_RD   = 3'd3,
    R_WB   = 3'd4,
    W_WR   = 3'd5,
    CANCEL = 3'd6
  } state_e;

  localparam int ENTRY_W = 78;

  // LSB offsets of the packed entry {vpn2,asid,g,pfn0,c0,d0,v0,pfn1,c1,d1,v1}
  localparam int OFS_V1   = 0;
  localparam int OFS_D1   = 1;
  localparam int OFS_C1   = 2;
  localparam int OFS_PFN1 = 5;
  localparam int OFS_V0   = 25;
  localparam int OFS_D0   = 26;
  localparam int OFS_C0   = 27;
  localparam int OFS_PFN0 = 30;
  localparam int OFS_G    = 50;
  localparam int OFS_ASID = 51;
  localparam int OFS_VPN2 = 59;

  localparam logic [2:0] WAIT_MAX = 3'd7;

  // Saturating increment for the search-port wait counter
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == WAIT_MAX) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/tlb_entry_pack.sv
// Builds a packed TLB entry from the CP0 EntryHi/EntryLo0/EntryLo1 values.
module tlb_entry_pack
  import tlb_op_ctrl_pkg::*;
(
  input  logic [31:0]        entryhi,
  input  logic [31:0]        entrylo0,
  input  logic [31:0]        entrylo1,
  output logic [ENTRY_W-1:0] entry
);

  // Bits of the CP0 registers that have no place in an entry
  logic unused_bits;
  assign unused_bits = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26]};

  // The global bit is only set when both halves mark the page global
  always_comb begin
    entry = '0;
    entry[OFS_VPN2 +: 19] = entryhi[31:13];
    entry[OFS_ASID +: 8]  = entryhi[7:0];
    entry[OFS_G]          = entrylo0[0] & entrylo1[0];
    entry[OFS_PFN0 +: 20] = entrylo0[25:6];
    entry[OFS_C0 +: 3]    = entrylo0[5:3];
    entry[OFS_D0]         = entrylo0[2];
    entry[OFS_V0]         = entrylo0[1];
    entry[OFS_PFN1 +: 20] = entrylo1[25:6];
    entry[OFS_C1 +: 3]    = entrylo1[5:3];
    entry[OFS_D1]         = entrylo1[2];
    entry[OFS_V1]         = entrylo1[1];
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI ops handed over by writeback. CP0 state is
// captured once at acceptance; all completion pulses come from flops.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         op_type,
  input  logic [31:0]        op_pc,
  input  logic               flush,
  input  logic [31:0]        cp0_index,
  input  logic [31:0]        cp0_entryhi,
  input  logic [31:0]        cp0_entrylo0,
  input  logic [31:0]        cp0_entrylo1,
  output logic               s1_req,
  input  logic               s1_gnt,
  output logic               s1_urgent,
  output logic [18:0]        s1_vpn2,
  output logic [7:0]         s1_asid,
  input  logic               s1_found,
  input  logic [3:0]         s1_index,
  output logic [3:0]         r_index,
  input  logic [ENTRY_W-1:0] r_entry,
  output logic               we,
  output logic [3:0]         w_index,
  output logic [ENTRY_W-1:0] w_entry,
  output logic               tlbp_we,
  output logic               tlbp_p,
  output logic [3:0]         tlbp_index,
  output logic               tlbr_we,
  output logic [ENTRY_W-1:0] tlbr_data,
  output logic               cancel_valid,
  output logic [31:0]        cancel_pc,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [2:0]           wcnt_q, wcnt_d;
  logic [1:0]           op_type_q, op_type_d;
  logic [31:0]          pc_q, pc_d;
  logic [3:0]           idx_q, idx_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo0_q, lo0_d;
  logic [31:0]          lo1_q, lo1_d;
  logic                 tlbp_we_q, tlbp_we_d;
  logic                 tlbp_p_q, tlbp_p_d;
  logic [3:0]           tlbp_index_q, tlbp_index_d;
  logic                 tlbr_we_q, tlbr_we_d;
  logic [ENTRY_W-1:0]   tlbr_data_q, tlbr_data_d;
  logic                 we_q, we_d;
  logic                 cancel_valid_q, cancel_valid_d;
  logic [31:0]          cancel_pc_q, cancel_pc_d;

  // The op type is only needed for dispatch but is kept in the snapshot
  logic unused_snap;
  assign unused_snap = ^{cp0_index[31:4], op_type_q};

  tlb_entry_pack u_pack (
    .entryhi  (hi_q),
    .entrylo0 (lo0_q),
    .entrylo1 (lo1_q),
    .entry    (w_entry)
  );

  // Next-state, snapshot capture and pulse generation; each pulse is keyed
  // off the state being entered so only one can be set per cycle
  always_comb begin
    state_d      = state_q;
    wcnt_d       = 3'd0;
    op_type_d    = op_type_q;
    pc_d         = pc_q;
    idx_d        = idx_q;
    hi_d         = hi_q;
    lo0_d        = lo0_q;
    lo1_d        = lo1_q;
    tlbp_p_d     = tlbp_p_q;
    tlbp_index_d = tlbp_index_q;
    tlbr_data_d  = tlbr_data_q;
    cancel_pc_d  = cancel_pc_q;

    case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          op_type_d = op_type;
          pc_d      = op_pc;
          idx_d     = cp0_index[3:0];
          hi_d      = cp0_entryhi;
          lo0_d     = cp0_entrylo0;
          lo1_d     = cp0_entrylo1;
          case (tlb_op_e'(op_type))
            OP_TLBP:  state_d = P_REQ;
            OP_TLBR:  state_d = R_RD;
            OP_TLBWI: state_d = W_WR;
            default:  state_d = IDLE;
          endcase
        end
      end
      P_REQ: begin
        // A flush beats a same-cycle grant; the search result is dropped
        if (flush) begin
          state_d = IDLE;
        end else if (s1_gnt) begin
          tlbp_p_d     = ~s1_found;
          tlbp_index_d = s1_found ? s1_index : 4'd0;
          state_d      = P_WB;
        end else begin
          wcnt_d = sat_inc3(wcnt_q);
        end
      end
      P_WB: state_d = IDLE;
      R_RD: begin
        tlbr_data_d = r_entry;
        state_d     = R_WB;
      end
      R_WB: begin
        cancel_pc_d = pc_q + 32'd4;
        state_d     = CANCEL;
      end
      W_WR: begin
        cancel_pc_d = pc_q + 32'd4;
        state_d     = CANCEL;
      end
      CANCEL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tlbp_we_d      = (state_d == P_WB);
    tlbr_we_d      = (state_d == R_WB);
    we_d           = (state_d == W_WR);
    cancel_valid_d = (state_d == CANCEL);
  end

  // State, snapshot and output registers with asynchronous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      wcnt_q         <= 3'd0;
      op_type_q      <= 2'd0;
      pc_q           <= 32'd0;
      idx_q          <= 4'd0;
      hi_q           <= 32'd0;
      lo0_q          <= 32'd0;
      lo1_q          <= 32'd0;
      tlbp_we_q      <= 1'b0;
      tlbp_p_q       <= 1'b0;
      tlbp_index_q   <= 4'd0;
      tlbr_we_q      <= 1'b0;
      tlbr_data_q    <= '0;
      we_q           <= 1'b0;
      cancel_valid_q <= 1'b0;
      cancel_pc_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      op_type_q      <= op_type_d;
      pc_q           <= pc_d;
      idx_q          <= idx_d;
      hi_q           <= hi_d;
      lo0_q          <= lo0_d;
      lo1_q          <= lo1_d;
      tlbp_we_q      <= tlbp_we_d;
      tlbp_p_q       <= tlbp_p_d;
      tlbp_index_q   <= tlbp_index_d;
      tlbr_we_q      <= tlbr_we_d;
      tlbr_data_q    <= tlbr_data_d;
      we_q           <= we_d;
      cancel_valid_q <= cancel_valid_d;
      cancel_pc_q    <= cancel_pc_d;
    end
  end

  assign op_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign s1_req       = (state_q == P_REQ);
  assign s1_urgent    = s1_req && (wcnt_q == WAIT_MAX);
  assign s1_vpn2      = hi_q[31:13];
  assign s1_asid      = hi_q[7:0];
  assign r_index      = idx_q;
  assign w_index      = idx_q;
  assign we           = we_q;
  assign tlbp_we      = tlbp_we_q;
  assign tlbp_p       = tlbp_p_q;
  assign tlbp_index   = tlbp_index_q;
  assign tlbr_we      = tlbr_we_q;
  assign tlbr_data    = tlbr_data_q;
  assign cancel_valid = cancel_valid_q;
  assign cancel_pc    = cancel_pc_q;

endmodule
